// File: rtl/pb3_binary_alu.sv
// pb3_binary_alu
// Purely combinational 16-bit binary ALU for the phase-3 datapath.
// The result bus y follows the operands and opcode at all times. The two
// flag outputs are only ever asserted while the bus strobe nboe is low and
// the block is out of reset, so they stay quiet while operands change.
//
// Ports
//   nreset   in   1  asynchronous active-low reset (holds flags inactive)
//   clk3     in   1  phase-3 clock, present for bus uniformity, not used
//   nboe     in   1  active-low bus-output / flag-strobe enable
//   fl       in   1  current link flag, carry-in for ADC
//   ac       in  16  accumulator operand
//   b        in  16  B-register operand
//   runit    in   4  operation select (8 ADD, 9 AND, 10 OR, 11 XOR, 12 ADC)
//   y        out 16  result
//   fv       out  1  active-high signed-overflow flag
//   nfltadd  out  1  active-low "toggle link on carry" strobe

module pb3_binary_alu (
   input  logic        nreset,
   input  logic        clk3,
   input  logic        nboe,
   input  logic        fl,
   input  logic [15:0] ac,
   input  logic [15:0] b,
   input  logic [3:0]  runit,
   output logic [15:0] y,
   output logic        fv,
   output logic        nfltadd
);

   localparam logic [3:0] OpAdd = 4'd8;
   localparam logic [3:0] OpAnd = 4'd9;
   localparam logic [3:0] OpOr  = 4'd10;
   localparam logic [3:0] OpXor = 4'd11;
   localparam logic [3:0] OpAdc = 4'd12;

   logic        unusedClk;
   logic        isArith;
   logic        carryIn;
   logic [4:0]  sliceLo;
   logic [8:0]  sliceMid;
   logic [4:0]  sliceHi;
   logic [15:0] sum;
   logic        carryOut;
   logic        overflow;
   logic        flagEnable;

   // The clock only exists so every datapath unit has the same pinout.
   assign unusedClk = clk3;

   // Decode which operations are arithmetic; only ADC takes the link flag in.
   always_comb begin
      isArith = (runit == OpAdd) || (runit == OpAdc);
      carryIn = (runit == OpAdc) ? fl : 1'b0;
   end

   // Adder built as three ripple-cascaded slices (4 + 8 + 4 bits), matching
   // the original carry chain; the top slice's carry is bit 16 of the sum.
   always_comb begin
      sliceLo  = {1'b0, ac[3:0]}  + {1'b0, b[3:0]}  + {4'b0000, carryIn};
      sliceMid = {1'b0, ac[11:4]} + {1'b0, b[11:4]} + {8'h00, sliceLo[4]};
      sliceHi  = {1'b0, ac[15:12]} + {1'b0, b[15:12]} + {4'b0000, sliceMid[8]};
      sum      = {sliceHi[3:0], sliceMid[7:0], sliceLo[3:0]};
      carryOut = sliceHi[4];
   end

   // Result mux; unused opcodes drive an all-zero bus.
   always_comb begin
      y = 16'h0000;
      unique case (runit)
         OpAdd:   y = sum;
         OpAnd:   y = ac & b;
         OpOr:    y = ac | b;
         OpXor:   y = ac ^ b;
         OpAdc:   y = sum;
         default: y = 16'h0000;
      endcase
   end

   // Signed overflow: operands agree in sign but the sum's sign differs.
   // Flags are gated by reset, the strobe and the arithmetic decode, so a
   // logic op or an operand change with nboe high can never pulse them.
   always_comb begin
      overflow   = (ac[15] == b[15]) && (sum[15] != ac[15]);
      flagEnable = nreset && !nboe && isArith;
      fv         = flagEnable && overflow;
      nfltadd    = !(flagEnable && carryOut);
   end

endmodule

// File: tb/tb_pb3_binary_alu.sv
// tb_pb3_binary_alu
// Scoreboard bench for pb3_binary_alu: each applied vector pushes its
// expected y/fv/nfltadd, which are popped and compared once the
// combinational outputs have settled.

module tb_pb3_binary_alu;

   typedef struct packed {
      logic [15:0] y;
      logic        fv;
      logic        nfltadd;
   } expT;

   logic        clk3;
   logic        nreset;
   logic        nboe;
   logic        fl;
   logic [15:0] ac;
   logic [15:0] b;
   logic [3:0]  runit;
   logic [15:0] y;
   logic        fv;
   logic        nfltadd;

   expT   expQueue[$];
   string tagQueue[$];
   int    testsRun;
   int    testsFailed;

   pb3_binary_alu dut (
      .nreset  (nreset),
      .clk3    (clk3),
      .nboe    (nboe),
      .fl      (fl),
      .ac      (ac),
      .b       (b),
      .runit   (runit),
      .y       (y),
      .fv      (fv),
      .nfltadd (nfltadd)
   );

   // Free-running phase-3 clock; the DUT ignores it but the bench paces on it.
   initial begin
      clk3 = 1'b0;
      forever #5 clk3 = ~clk3;
   end

   // Independent reference of the ALU behaviour.
   function automatic expT model(input logic [15:0] a, input logic [15:0] bb,
                                 input logic [3:0] op, input logic cin,
                                 input logic oe_n, input logic rst_n);
      expT        e;
      logic [16:0] full;
      logic        arith;
      arith     = (op == 4'd8) || (op == 4'd12);
      full      = {1'b0, a} + {1'b0, bb} + ((op == 4'd12 && cin) ? 17'd1 : 17'd0);
      e.y       = 16'h0000;
      if (arith)        e.y = full[15:0];
      else if (op == 4'd9)  e.y = a & bb;
      else if (op == 4'd10) e.y = a | bb;
      else if (op == 4'd11) e.y = a ^ bb;
      e.fv      = arith && rst_n && !oe_n && (a[15] == bb[15]) && (full[15] != a[15]);
      e.nfltadd = !(arith && rst_n && !oe_n && full[16]);
      return e;
   endfunction

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
      end
   endtask

   // Drive one vector and queue either a directed or a modelled expectation.
   task automatic applyStimulus(input string tag, input logic rst_n, input logic oe_n,
                                input logic cin, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] bb);
      @(posedge clk3);
      #1;
      nreset = rst_n;
      nboe   = oe_n;
      fl     = cin;
      runit  = op;
      ac     = a;
      b      = bb;
      expQueue.push_back(model(a, bb, op, cin, oe_n, rst_n));
      tagQueue.push_back(tag);
   endtask

   task automatic applyDirected(input string tag, input logic rst_n, input logic oe_n,
                                input logic cin, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] bb,
                                input logic [15:0] ey, input logic efv, input logic enf);
      expT e;
      applyStimulus(tag, rst_n, oe_n, cin, op, a, bb);
      void'(expQueue.pop_back());
      e.y = ey; e.fv = efv; e.nfltadd = enf;
      expQueue.push_back(e);
   endtask

   // Pop the oldest expectation and compare it against the outputs right now.
   task automatic checkPending();
      expT   e;
      string t;
      if (expQueue.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: queue empty, expected an entry");
      end else begin
         e = expQueue.pop_front();
         t = tagQueue.pop_front();
         checkOutput({t, ".y"}, y, e.y);
         checkOutput({t, ".fv"}, {15'h0, fv}, {15'h0, e.fv});
         checkOutput({t, ".nfltadd"}, {15'h0, nfltadd}, {15'h0, e.nfltadd});
      end
   endtask

   task automatic sampleCheck();
      @(negedge clk3);
      checkPending();
   endtask

   initial begin
      logic [15:0] ga;
      logic [15:0] gb;
      logic [15:0] bv;
      testsRun    = 0;
      testsFailed = 0;
      nreset = 1'b0; nboe = 1'b1; fl = 1'b0; runit = 4'd0; ac = 16'h0; b = 16'h0;

      // Reset state: unused opcode, flags inactive.
      applyDirected("reset", 1'b0, 1'b0, 1'b0, 4'd0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1);
      sampleCheck();

      // OR with a strobe pulse: flags must stay inactive.
      applyDirected("or_strobe_hi", 1'b1, 1'b1, 1'b0, 4'd10, 16'h1234, 16'h8001, 16'h9235, 1'b0, 1'b1);
      sampleCheck();
      applyDirected("or_strobe_lo", 1'b1, 1'b0, 1'b0, 4'd10, 16'h1234, 16'h8001, 16'h9235, 1'b0, 1'b1);
      sampleCheck();

      // ADD overflow and carry boundaries.
      applyDirected("add_ovf", 1'b1, 1'b0, 1'b0, 4'd8, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b1);
      sampleCheck();
      applyDirected("add_carry", 1'b1, 1'b0, 1'b0, 4'd8, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0);
      sampleCheck();
      applyDirected("add_nboe_hi", 1'b1, 1'b1, 1'b1, 4'd8, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1);
      sampleCheck();
      applyDirected("add_ignores_fl", 1'b1, 1'b0, 1'b1, 4'd8, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b1);
      sampleCheck();

      // ADC, AND, XOR directed vectors.
      applyDirected("adc_fl", 1'b1, 1'b0, 1'b1, 4'd12, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b1);
      sampleCheck();
      applyDirected("adc_carry_chain", 1'b1, 1'b0, 1'b1, 4'd12, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0);
      sampleCheck();
      applyDirected("and", 1'b1, 1'b0, 1'b0, 4'd9, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b1);
      sampleCheck();
      applyDirected("xor", 1'b1, 1'b0, 1'b0, 4'd11, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b1);
      sampleCheck();
      applyDirected("undef_op", 1'b1, 1'b0, 1'b1, 4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
      sampleCheck();

      // Reset holds flags off; release takes effect with no clock edge.
      applyDirected("rst_hold", 1'b0, 1'b0, 1'b0, 4'd8, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1);
      sampleCheck();
      @(posedge clk3);
      #2;
      nreset = 1'b1;
      expQueue.push_back('{y: 16'h0000, fv: 1'b1, nfltadd: 1'b0});
      tagQueue.push_back("rst_release");
      #1;
      checkPending();

      // OR sweep on a stride-21553 grid with derived b patterns.
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ga = 16'(i * 21553);
            gb = 16'(j * 21553);
            for (int k = 0; k < 4; k++) begin
               case (k)
                  0:       bv = gb;
                  1:       bv = gb ^ 16'h5555;
                  2:       bv = gb ^ 16'hAAAA;
                  default: bv = -gb;
               endcase
               applyStimulus("or_sweep", 1'b1, 1'(k & 1), 1'b1, 4'd10, ga, bv);
               sampleCheck();
            end
         end
      end

      // Random arithmetic vectors against the reference model.
      for (int n = 0; n < 40; n++) begin
         applyStimulus("arith_rand", 1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom),
                       ($urandom_range(0, 1) == 1) ? 4'd12 : 4'd8,
                       16'($urandom), 16'($urandom));
         sampleCheck();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Safety net so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
